// File: rtl/key_command_unit.sv
// Purpose: synchronises key flags, turns key presses into commands in a one-entry slot,
//          drives the game reset pulse and a free-running clock enable. Define KEY_CMD_AUTOREPEAT_EN for auto-repeat.
// Latency: key rise -> cmd_valid at the third rising clk edge. Backpressure: slot held until cmd_ready; overflow pulses cmd_drop.
module key_command_unit #(
  parameter int NUM_KEYS      = 4,
  parameter int RST_KEY       = 2,
  parameter int RST_PULSE     = 100,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int DIV_LOG2      = 2,
  localparam int CMD_W        = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                cmd_ready,
  output logic                cmd_valid,
  output logic [CMD_W-1:0]    cmd_code,
  output logic                cmd_drop,
  output logic                game_rst_n,
  output logic                tick_ce
);

  localparam int RC_W = $clog2(RST_PULSE + 1);
  localparam logic [RC_W-1:0] RST_LOAD   = RC_W'(RST_PULSE);
  localparam logic [RC_W-1:0] RST_RELOAD = RC_W'(RST_PULSE - 1);

  logic [NUM_KEYS-1:0] key_s1;
  logic [NUM_KEYS-1:0] key_s2;
  logic [NUM_KEYS-1:0] key_s3;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] edge_mask;
  logic                edge_hit;
  logic [CMD_W-1:0]    edge_code;
  logic                rst_rise;
  logic                hold;
  logic [RC_W-1:0]     rst_cnt;
  logic [DIV_LOG2-1:0] div_cnt;
  logic                new_vld;
  logic [CMD_W-1:0]    new_code;

  // Two-flop synchroniser plus a registered copy for rising-edge detection.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_s1 <= '0;
      key_s2 <= '0;
      key_s3 <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  assign rise     = key_s2 & ~key_s3;
  assign rst_rise = rise[RST_KEY];
  // Game logic is held while the reset pulse is active, including the cycle that triggers it.
  assign hold     = rst_rise | ~game_rst_n;

  // Pick the lowest-index command key with a rising edge; the reset key never becomes a command.
  always_comb begin
    edge_hit  = 1'b0;
    edge_mask = '0;
    edge_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (i != RST_KEY && rise[i]) begin
        edge_hit     = 1'b1;
        edge_mask    = '0;
        edge_mask[i] = 1'b1;
        edge_code    = CMD_W'(i + 1);
      end
    end
  end

  // Game reset pulse: a reset-key edge (re)starts the full count; clrn also arms a full pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rst_cnt    <= RST_LOAD;
      game_rst_n <= 1'b0;
    end else if (rst_rise) begin
      rst_cnt    <= RST_RELOAD;
      game_rst_n <= 1'b0;
    end else if (rst_cnt != '0) begin
      rst_cnt    <= rst_cnt - 1'b1;
      game_rst_n <= 1'b0;
    end else begin
      game_rst_n <= 1'b1;
    end
  end

  // Free-running divider; deliberately ignores the game reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick_ce = &div_cnt;

`ifdef KEY_CMD_AUTOREPEAT_EN
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [1:0]          rep_state;
  logic [RW-1:0]       rep_cnt;
  logic [NUM_KEYS-1:0] trk_mask;
  logic [CMD_W-1:0]    trk_code;
  logic [NUM_KEYS-1:0] held_mask;
  logic                trk_edge;
  logic                trk_held;
  logic                rep_fire;

  // One-hot of the lowest-index held command key: the only key allowed to auto-repeat.
  always_comb begin
    held_mask = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (i != RST_KEY && key_s2[i]) begin
        held_mask    = '0;
        held_mask[i] = 1'b1;
      end
    end
  end

  assign trk_edge = edge_hit & (edge_mask == held_mask);
  assign trk_held = |(key_s2 & trk_mask);
  // An edge command in the same cycle outranks the repeat, which is then simply lost.
  assign rep_fire = (rep_state != ST_IDLE) & ~hold & ~trk_edge & trk_held & (rep_cnt == RW'(1));

  // Repeat FSM: delay after the press, then periodic repeats while the tracked key stays held.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rep_state <= ST_IDLE;
      rep_cnt   <= '0;
      trk_mask  <= '0;
      trk_code  <= '0;
    end else if (hold) begin
      rep_state <= ST_IDLE;
    end else if (trk_edge) begin
      rep_state <= ST_DELAY;
      rep_cnt   <= RW'(REPEAT_DELAY);
      trk_mask  <= edge_mask;
      trk_code  <= edge_code;
    end else if (rep_state != ST_IDLE) begin
      if (!trk_held) begin
        rep_state <= ST_IDLE;
      end else if (rep_cnt == RW'(1)) begin
        rep_state <= ST_REPEAT;
        rep_cnt   <= RW'(REPEAT_PERIOD);
      end else begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end

  assign new_vld  = edge_hit | rep_fire;
  assign new_code = edge_hit ? edge_code : trk_code;
`else
  assign new_vld  = edge_hit;
  assign new_code = edge_code;
`endif

  // One-entry command slot: load when empty or draining this cycle, otherwise report the loss.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_drop  <= 1'b0;
    end else begin
      cmd_drop <= 1'b0;
      if (hold) begin
        cmd_valid <= 1'b0;
        cmd_code  <= '0;
      end else if (new_vld) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid <= 1'b1;
          cmd_code  <= new_code;
        end else begin
          cmd_drop <= 1'b1;
        end
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        cmd_code  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_key_command_unit.sv
// Testbench for key_command_unit: directed scenarios plus random key/ready traffic,
// every cycle compared against a behavioural model of the command rules.
module tb_key_command_unit;
  localparam int NK   = 4;
  localparam int RK   = 2;
  localparam int RP   = 100;
  localparam int RD   = 8;
  localparam int RPER = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          clrn;
  logic [NK-1:0] key;
  logic          cmd_ready;
  logic          cmd_valid;
  logic [CW-1:0] cmd_code;
  logic          cmd_drop;
  logic          game_rst_n;
  logic          tick_ce;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_command_unit #(
    .NUM_KEYS(NK), .RST_KEY(RK), .RST_PULSE(RP),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RPER), .DIV_LOG2(2)
  ) dut (
    .clk(clk), .clrn(clrn), .key(key), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_drop(cmd_drop),
    .game_rst_n(game_rst_n), .tick_ce(tick_ce)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            n;          // clock edges since clrn released
  logic [NK-1:0] smp[4];     // key samples at the last four edges, [0] newest
  int            low_until;  // edge index at which game_rst_n returns high
  logic          m_valid;
  int            m_code;
  logic          m_drop;
  int            trk;        // key being auto-repeated, -1 when none
  int            age;        // edges since the tracked key's press command

  task automatic m_reset();
    n = 0;
    for (int i = 0; i < 4; i++) smp[i] = '0;
    low_until = RP + 1;
    m_valid = 1'b0;
    m_code  = 0;
    m_drop  = 1'b0;
    trk     = -1;
    age     = 0;
  endtask

  task automatic m_step();
    logic [NK-1:0] seen;
    logic [NK-1:0] rise;
    logic          hold;
    int            ec;
    int            low_held;
    int            newc;
    int            repc;
    logic          rep;
    n++;
    smp[3] = smp[2]; smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = key;
    seen = smp[2];                 // key as seen through the two-flop synchroniser
    rise = smp[2] & ~smp[3];
    hold = rise[RK] || !((n - 1) >= low_until);
    if (rise[RK]) low_until = n + RP;
    ec = 0;
    low_held = -1;
    for (int i = NK - 1; i >= 0; i--) begin
      if (i != RK && rise[i]) ec = i + 1;
      if (i != RK && seen[i]) low_held = i;
    end
    m_drop = 1'b0;
    if (hold) begin
      m_valid = 1'b0;
      m_code  = 0;
      trk     = -1;
    end else begin
      rep  = 1'b0;
      repc = trk + 1;
`ifdef KEY_CMD_AUTOREPEAT_EN
      if (trk >= 0) begin
        if (!seen[trk]) trk = -1;
        else begin
          age++;
          if (age == RD || (age > RD && (age - RD) % RPER == 0)) rep = 1'b1;
        end
      end
      if (ec != 0 && ec - 1 == low_held) begin
        trk = ec - 1;
        age = 0;
      end
`endif
      newc = (ec != 0) ? ec : (rep ? repc : 0);
      if (newc != 0) begin
        if (!m_valid || cmd_ready) begin
          m_valid = 1'b1;
          m_code  = newc;
        end else m_drop = 1'b1;
      end else if (m_valid && cmd_ready) begin
        m_valid = 1'b0;
        m_code  = 0;
      end
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs just after it.
  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    check("cmd_valid", cmd_valid, m_valid);
    check("cmd_code", cmd_code, m_code);
    check("cmd_drop", cmd_drop, m_drop);
    check("game_rst_n", game_rst_n, (n >= low_until));
    check("tick_ce", tick_ce, ((n % 4) == 3));
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 0);
    check("rst_drop", cmd_drop, 0);
    check("rst_tick", tick_ce, 0);
    check("rst_game", game_rst_n, 0);
    repeat (5) @(posedge clk);
    #1;
    clrn = 1'b1;
    m_reset();
  endtask

  task automatic wait_game_up();
    for (int i = 0; i < 300; i++) begin
      if (game_rst_n) break;
      cyc();
    end
    check("game_up_timeout", game_rst_n, 1);
  endtask

  int cnt_a, cnt_b, first_t, rb;
  logic seen_drop;

  initial begin
    clrn = 1'b0;
    key = '0;
    cmd_ready = 1'b0;
    m_reset();
    @(posedge clk);
    #1;

    // Power-up: game reset lasts the full pulse after clrn release, no commands.
    do_reset();
    cnt_a = 0; cnt_b = 0;
    for (int t = 0; t < 300; t++) begin
      cyc();
      if (cmd_valid) cnt_b++;
      if (game_rst_n) break;
      cnt_a++;
    end
    check("pwrup_low_len", cnt_a, RP);
    check("pwrup_no_cmd", cnt_b, 0);

    // Clock enable keeps its rhythm across a game reset pulse.
    cnt_a = 0;
    for (int t = 0; t < 64; t++) begin
      key[RK] = (t < 3);
      cyc();
      if (tick_ce) cnt_a++;
    end
    check("tick_count", cnt_a, 16);
    wait_game_up();

    // Single held key with ready high: first command at third edge, optional repeats.
    cmd_ready = 1'b1;
    cnt_a = 0; first_t = -1;
    for (int t = 0; t < 40; t++) begin
      key[0] = (t < 30);
      cyc();
      if (cmd_valid) begin
        cnt_a++;
        if (first_t < 0) begin
          first_t = t;
          check("first_code", cmd_code, 1);
        end
      end
    end
    check("first_latency", first_t, 2);
`ifdef KEY_CMD_AUTOREPEAT_EN
    check("press_cmd_count", cnt_a, 7);
`else
    check("press_cmd_count", cnt_a, 1);
`endif

    // Simultaneous presses with ready low, then a re-press into the full slot.
    cmd_ready = 1'b0;
    seen_drop = 1'b0;
    for (int t = 0; t < 12; t++) begin
      key = (t >= 5 && t < 7) ? 4'b0010 : 4'b1010;
      cyc();
      if (t < 7 && cmd_drop) seen_drop = 1'b1;
      if (t == 3) check("simul_code", cmd_code, 2);
      if (t == 9) begin
        check("repress_drop", cmd_drop, 1);
        check("repress_code", cmd_code, 2);
      end
    end
    check("simul_no_drop", seen_drop, 0);

    // New edge lands on the handshake cycle of the pending command.
    key = '0;
    repeat (3) cyc();
    for (int t = 0; t < 4; t++) begin
      key[0] = 1'b1;
      cmd_ready = (t == 2);
      cyc();
      if (t == 2) begin
        check("hs_load_valid", cmd_valid, 1);
        check("hs_load_code", cmd_code, 1);
        check("hs_load_drop", cmd_drop, 0);
      end
    end
    key = '0;
    cmd_ready = 1'b1;
    repeat (4) cyc();

    // Second reset-key press 50 cycles after the first stretches the pulse to 150.
    cnt_a = 0; cnt_b = 0;
    for (int t = 0; t < 400; t++) begin
      key[RK] = (t < 3) || (t >= 50 && t < 53);
      key[0]  = (t >= 80 && t < 90);
      cyc();
      if (!game_rst_n) cnt_a++;
      if (cmd_valid) cnt_b++;
      if (t > 60 && game_rst_n) break;
    end
    check("restart_low_len", cnt_a, 150);
    check("restart_no_cmd", cnt_b, 0);

    // clrn in the middle of a game reset pulse.
    key[RK] = 1'b1;
    repeat (3) cyc();
    key[RK] = 1'b0;
    repeat (20) cyc();
    do_reset();
    wait_game_up();

    // Random traffic, with one asynchronous reset part way through.
    for (int c = 0; c < 2500; c++) begin
      if (c == 1200) begin
        do_reset();
      end
      if ($urandom_range(0, 5) == 0) begin
        rb = $urandom_range(0, NK - 1);
        if (rb != RK) key[rb] = ~key[rb];
      end
      if ($urandom_range(0, 299) == 0) key[RK] = ~key[RK];
      cmd_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
